pack_arbiter: RTL

Packet-granular round-robin arbiter that shares the single packet-write port of the output packet buffer among NREQ independent packet sources (e.g. several trace decoders). It grants one requester at a time for a whole packet, forwards its 16-bit words, commit and abort onto the buffer's WdAvail/PacketWd/PacketCommit/PacketReset inputs, and enforces a per-packet word limit and an inactivity timeout so that one stalled source cannot block the port. It sits in the buffer's write-clock domain, directly upstream of the packet buffer.

---
 rtl/pack_arbiter_if.sv | 28 ++
 rtl/pack_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pack_arbiter_if.sv
// Requester-side and buffer-side signals of the packet-write arbiter.
// The arbiter uses the slave view; sources and the packet buffer use the master view.
interface pack_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    reqStart;
  logic [NREQ-1:0]    reqWdAvail;
  logic [16*NREQ-1:0] reqWd;
  logic [NREQ-1:0]    reqCommit;
  logic [NREQ-1:0]    reqAbort;
  logic [NREQ-1:0]    reqGrant;
  logic               WdAvail;
  logic [15:0]        PacketWd;
  logic               PacketCommit;
  logic               PacketReset;
  logic               errPulse;
  logic [15:0]        dropCnt;

  modport slave (
    input  reqStart, reqWdAvail, reqWd, reqCommit, reqAbort,
    output reqGrant, WdAvail, PacketWd, PacketCommit, PacketReset, errPulse, dropCnt
  );

  modport master (
    output reqStart, reqWdAvail, reqWd, reqCommit, reqAbort,
    input  reqGrant, WdAvail, PacketWd, PacketCommit, PacketReset, errPulse, dropCnt
  );
endinterface

// File: rtl/pack_arbiter.sv
// Packet-granular round-robin arbiter sharing the packet buffer's write port.
// One requester owns the port per packet; a word limit and an idle timeout bound each grant.
module pack_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXWORDS = 64,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  pack_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(MAXWORDS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, GAP} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] rrPtr_q, rrPtr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [CNTW-1:0] wordCnt_q, wordCnt_d;
  logic [15:0]     idleCnt_q, idleCnt_d;
  logic            pend_q, pend_d;
  logic            wdAvail_q, wdAvail_d;
  logic            commit_q, commit_d;
  logic            reset_q, reset_d;
  logic            err_q, err_d;
  logic [15:0]     packetWd_q, packetWd_d;
  logic [15:0]     dropCnt_q, dropCnt_d;

  logic            anyReq;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] cand;
  logic            selAvail, selCommit, selAbort;
  logic [15:0]     selWd;
  logic            endPkt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // First requester at or after rrPtr, wrapping modulo NREQ.
  always_comb begin
    anyReq = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDXW'((int'(rrPtr_q) + k) % NREQ);
      if (!anyReq && bus.reqStart[cand]) begin
        anyReq = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    selAvail  = 1'b0;
    selCommit = 1'b0;
    selAbort  = 1'b0;
    selWd     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx_q == IDXW'(i)) begin
        selAvail  = bus.reqWdAvail[i];
        selCommit = bus.reqCommit[i];
        selAbort  = bus.reqAbort[i];
        selWd     = bus.reqWd[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    idx_d      = idx_q;
    grant_d    = grant_q;
    wordCnt_d  = wordCnt_q;
    idleCnt_d  = idleCnt_q;
    pend_d     = pend_q;
    wdAvail_d  = 1'b0;
    commit_d   = 1'b0;
    reset_d    = 1'b0;
    err_d      = 1'b0;
    packetWd_d = packetWd_q;
    dropCnt_d  = dropCnt_q;
    endPkt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d         = BUSY;
          idx_d           = winner;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          rrPtr_d         = (winner == IDXW'(NREQ - 1)) ? '0 : winner + 1'b1;
          wordCnt_d       = '0;
          idleCnt_d       = '0;
          pend_d          = 1'b0;
        end
      end
      BUSY: begin
        // A commit that arrived with the last word goes out the cycle after it.
        if (pend_q) begin
          commit_d = 1'b1;
          endPkt   = 1'b1;
        end else if (selAbort) begin
          reset_d   = 1'b1;
          dropCnt_d = sat_inc(dropCnt_q);
          endPkt    = 1'b1;
        end else if (selAvail && wordCnt_q == CNTW'(MAXWORDS)) begin
          reset_d   = 1'b1;
          err_d     = 1'b1;
          dropCnt_d = sat_inc(dropCnt_q);
          if (selCommit) endPkt  = 1'b1;
          else           state_d = DRAIN;
        end else if (selAvail) begin
          wdAvail_d  = 1'b1;
          packetWd_d = selWd;
          wordCnt_d  = wordCnt_q + 1'b1;
          idleCnt_d  = '0;
          pend_d     = selCommit;
        end else if (selCommit) begin
          commit_d = 1'b1;
          endPkt   = 1'b1;
        end else if (idleCnt_q == 16'(TIMEOUT - 1)) begin
          reset_d   = 1'b1;
          err_d     = 1'b1;
          dropCnt_d = sat_inc(dropCnt_q);
          endPkt    = 1'b1;
        end else begin
          idleCnt_d = idleCnt_q + 16'd1;
        end
      end
      DRAIN: begin
        if (selCommit || selAbort) endPkt = 1'b1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (endPkt) begin
      state_d = GAP;
      grant_d = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rrPtr_q    <= '0;
      idx_q      <= '0;
      grant_q    <= '0;
      wordCnt_q  <= '0;
      idleCnt_q  <= '0;
      pend_q     <= 1'b0;
      wdAvail_q  <= 1'b0;
      commit_q   <= 1'b0;
      reset_q    <= 1'b0;
      err_q      <= 1'b0;
      packetWd_q <= '0;
      dropCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      wordCnt_q  <= wordCnt_d;
      idleCnt_q  <= idleCnt_d;
      pend_q     <= pend_d;
      wdAvail_q  <= wdAvail_d;
      commit_q   <= commit_d;
      reset_q    <= reset_d;
      err_q      <= err_d;
      packetWd_q <= packetWd_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  assign bus.reqGrant     = grant_q;
  assign bus.WdAvail      = wdAvail_q;
  assign bus.PacketWd     = packetWd_q;
  assign bus.PacketCommit = commit_q;
  assign bus.PacketReset  = reset_q;
  assign bus.errPulse     = err_q;
  assign bus.dropCnt      = dropCnt_q;
endmodule
